// File: rtl/branch_resolve_pkg.sv
// Shared encodings for the branch-resolve stage: branch kinds, condition codes,
// flag bit positions and datapath widths.
package branch_resolve_pkg;

  localparam int WORDSIZE = 64;
  localparam int OFFSIZE  = 26;

  typedef logic [2:0] brkind_t;
  localparam brkind_t BRKIND_NONE  = 3'd0;
  localparam brkind_t BRKIND_B     = 3'd1;
  localparam brkind_t BRKIND_BCOND = 3'd2;
  localparam brkind_t BRKIND_CBZ   = 3'd3;
  localparam brkind_t BRKIND_CBNZ  = 3'd4;
  localparam brkind_t BRKIND_BR    = 3'd5;

  typedef logic [3:0] cond_t;
  localparam cond_t COND_EQ = 4'h0;
  localparam cond_t COND_NE = 4'h1;
  localparam cond_t COND_HS = 4'h2;
  localparam cond_t COND_LO = 4'h3;
  localparam cond_t COND_MI = 4'h4;
  localparam cond_t COND_PL = 4'h5;
  localparam cond_t COND_VS = 4'h6;
  localparam cond_t COND_VC = 4'h7;
  localparam cond_t COND_HI = 4'h8;
  localparam cond_t COND_LS = 4'h9;
  localparam cond_t COND_GE = 4'hA;
  localparam cond_t COND_LT = 4'hB;
  localparam cond_t COND_GT = 4'hC;
  localparam cond_t COND_LE = 4'hD;
  localparam cond_t COND_AL = 4'hE;
  localparam cond_t COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

endpackage

// File: rtl/branch_resolve_cond_eval.sv
// Combinational condition-code evaluator against an NZVC flag vector; shared
// with conditional-select style instructions.
module branch_resolve_cond_eval
  import branch_resolve_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzvc,
  output logic       pass
);

  logic n, z, v, c;

  assign n = nzvc[FLAG_N];
  assign z = nzvc[FLAG_Z];
  assign v = nzvc[FLAG_V];
  assign c = nzvc[FLAG_C];

  always_comb begin
    pass = 1'b1;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_HS: pass = c;
      COND_LO: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~(c & ~z);
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = ~(~z & (n == v));
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-side branch resolution under predict-not-taken: owns the NZVC
// register, resolves branches and registers result/redirect for the memory stage.
module branch_resolve #(
  parameter int WORDSIZE = 64,
  parameter int OFFSIZE  = 26
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORDSIZE-1:0] in_res,
  input  logic [3:0]          in_flags,
  input  logic                in_setflags,
  input  logic [2:0]          in_kind,
  input  logic [3:0]          in_cond,
  input  logic [WORDSIZE-1:0] in_pc,
  input  logic [OFFSIZE-1:0]  in_off,
  input  logic                squash,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDSIZE-1:0] out_res,
  output logic                out_taken,
  output logic [WORDSIZE-1:0] out_target,
  output logic                flush,
  output logic [3:0]          nzvc
);

  import branch_resolve_pkg::*;

  logic                accept;
  logic                pass;
  logic                taken_d;
  logic [WORDSIZE-1:0] target_d;
  logic [WORDSIZE-1:0] off_ext;
  logic [WORDSIZE-1:0] seq_pc;
  logic [WORDSIZE-1:0] br_pc;

  // A taken branch at the output makes whatever sits at the input wrong-path.
  assign flush    = out_valid & out_taken;
  assign in_ready = (~out_valid | out_ready) & ~flush;
  assign accept   = in_valid & in_ready & ~squash;

  // Conditions read the committed flags; the producer wrote them on an earlier edge.
  branch_resolve_cond_eval u_cond_eval (
    .cond (in_cond),
    .nzvc (nzvc),
    .pass (pass)
  );

  assign off_ext = {{(WORDSIZE-OFFSIZE){in_off[OFFSIZE-1]}}, in_off};
  assign seq_pc  = in_pc + WORDSIZE'(4);
  assign br_pc   = in_pc + (off_ext << 2);

  always_comb begin
    taken_d = 1'b0;
    case (in_kind)
      BRKIND_B:     taken_d = 1'b1;
      BRKIND_BCOND: taken_d = pass;
      BRKIND_CBZ:   taken_d = (in_res == '0);
      BRKIND_CBNZ:  taken_d = (in_res != '0);
      BRKIND_BR:    taken_d = 1'b1;
      default:      taken_d = 1'b0;
    endcase

    target_d = seq_pc;
    if (taken_d) begin
      target_d = (in_kind == BRKIND_BR) ? in_res : br_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_taken  <= 1'b0;
      out_res    <= '0;
      out_target <= '0;
      nzvc       <= 4'b0000;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_taken  <= taken_d;
      out_res    <= in_res;
      out_target <= target_d;
      if (in_setflags) begin
        nzvc <= in_flags;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_taken <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed plus randomized bench for branch_resolve, checked against an
// architectural model of the stage kept in the bench.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_res = '0;
  logic [3:0]  in_flags = '0;
  logic        in_setflags = 1'b0;
  logic [2:0]  in_kind = '0;
  logic [3:0]  in_cond = '0;
  logic [63:0] in_pc = '0;
  logic [25:0] in_off = '0;
  logic        squash = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_res;
  logic        out_taken;
  logic [63:0] out_target;
  logic        flush;
  logic [3:0]  nzvc;

  int checks = 0;
  int errors = 0;

  logic        m_valid = 1'b0;
  logic        m_taken = 1'b0;
  logic [63:0] m_res = '0;
  logic [63:0] m_target = '0;
  logic [3:0]  m_nzvc = '0;

  branch_resolve #(.WORDSIZE(64), .OFFSIZE(26)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_res      (in_res),
    .in_flags    (in_flags),
    .in_setflags (in_setflags),
    .in_kind     (in_kind),
    .in_cond     (in_cond),
    .in_pc       (in_pc),
    .in_off      (in_off),
    .squash      (squash),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_res     (out_res),
    .out_taken   (out_taken),
    .out_target  (out_target),
    .flush       (flush),
    .nzvc        (nzvc)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Architectural condition meaning, one entry per mnemonic.
  function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
    bit n = f[3], z = f[2], v = f[1], cy = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic applyStimulus(input bit v, input int kind, input int cond, input logic [63:0] res,
                               input logic [3:0] flags, input bit sf, input logic [63:0] pc,
                               input logic [25:0] off, input bit sq, input bit ordy);
    in_valid    = v;
    in_kind     = 3'(kind);
    in_cond     = 4'(cond);
    in_res      = res;
    in_flags    = flags;
    in_setflags = sf;
    in_pc       = pc;
    in_off      = off;
    squash      = sq;
    out_ready   = ordy;
  endtask

  task automatic checkOutput();
    checkValue("out_valid", 64'(out_valid), 64'(m_valid));
    checkValue("flush", 64'(flush), 64'(m_valid && m_taken));
    checkValue("in_ready", 64'(in_ready), 64'((!m_valid || out_ready) && !(m_valid && m_taken)));
    checkValue("nzvc", 64'(nzvc), 64'(m_nzvc));
    if (m_valid) begin
      checkValue("out_taken", 64'(out_taken), 64'(m_taken));
      checkValue("out_res", out_res, m_res);
      checkValue("out_target", out_target, m_target);
    end
  endtask

  // Advance the model by one clock using the inputs currently presented.
  task automatic modelUpdate();
    bit          rdy;
    bit          tk;
    longint      soff;
    logic [63:0] tgt;
    rdy = (!m_valid || out_ready) && !(m_valid && m_taken);
    if (in_valid && rdy && !squash) begin
      case (in_kind)
        3'd1, 3'd5: tk = 1'b1;
        3'd2:       tk = ref_cond(in_cond, m_nzvc);
        3'd3:       tk = (in_res == 64'd0);
        3'd4:       tk = (in_res != 64'd0);
        default:    tk = 1'b0;
      endcase
      soff = longint'($signed(in_off));
      if (!tk)                tgt = in_pc + 64'd4;
      else if (in_kind == 5)  tgt = in_res;
      else                    tgt = in_pc + 64'(soff * 4);
      m_valid  = 1'b1;
      m_taken  = tk;
      m_res    = in_res;
      m_target = tgt;
      if (in_setflags) m_nzvc = in_flags;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    checkOutput();
    modelUpdate();
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(1, 0, 0, 64'h55, 4'hF, 1, 64'h40, 26'd0, 0, 1);
    repeat (3) begin
      @(negedge clk);
      checkValue("rst_out_valid", 64'(out_valid), 64'd0);
      checkValue("rst_nzvc", 64'(nzvc), 64'd0);
      checkValue("rst_flush", 64'(flush), 64'd0);
      checkValue("rst_out_taken", 64'(out_taken), 64'd0);
      checkValue("rst_out_res", out_res, 64'd0);
      checkValue("rst_out_target", out_target, 64'd0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(1, 0, 0, 64'h7, 4'b1010, 1, 64'hFC, 26'd0, 0, 1);
    step();
    checkValue("first_out_valid", 64'(out_valid), 64'd1);

    applyStimulus(1, 2, 'hA, 64'h0, 4'b0000, 0, 64'h100, 26'd3, 0, 1);
    step();
    checkValue("bge_nzvc", 64'(nzvc), 64'b1010);
    checkValue("bge_taken", 64'(out_taken), 64'd1);
    checkValue("bge_target", out_target, 64'h10C);
    checkValue("bge_flush", 64'(flush), 64'd1);

    applyStimulus(1, 0, 0, 64'h9, 4'b1000, 1, 64'h10C, 26'd0, 0, 1);
    step();
    checkValue("wrongpath_dropped", 64'(out_valid), 64'd0);
    checkValue("wrongpath_nzvc", 64'(nzvc), 64'b1010);

    step();
    checkValue("subs2_nzvc", 64'(nzvc), 64'b1000);

    applyStimulus(1, 2, 'hA, 64'h0, 4'b0000, 0, 64'h100, 26'd3, 0, 1);
    step();
    checkValue("bge_nt_taken", 64'(out_taken), 64'd0);
    checkValue("bge_nt_target", out_target, 64'h104);
    checkValue("bge_nt_flush", 64'(flush), 64'd0);

    applyStimulus(1, 3, 0, 64'h0, 4'b0000, 0, 64'h200, 26'h3FFFFFE, 0, 1);
    step();
    checkValue("cbz_taken", 64'(out_taken), 64'd1);
    checkValue("cbz_target", out_target, 64'h1F8);

    applyStimulus(0, 0, 0, 64'h0, 4'b0000, 0, 64'h0, 26'd0, 0, 1);
    step();

    applyStimulus(1, 4, 0, 64'h0, 4'b0000, 0, 64'h200, 26'h3FFFFFE, 0, 1);
    step();
    checkValue("cbnz_taken", 64'(out_taken), 64'd0);
    checkValue("cbnz_target", out_target, 64'h204);

    applyStimulus(1, 5, 0, 64'hDEAD0, 4'b0000, 0, 64'h300, 26'd0, 0, 1);
    step();
    applyStimulus(1, 0, 0, 64'h1, 4'b0101, 1, 64'h304, 26'd0, 0, 0);
    repeat (4) begin
      step();
      checkValue("stall_target", out_target, 64'hDEAD0);
      checkValue("stall_flush", 64'(flush), 64'd1);
      checkValue("stall_in_ready", 64'(in_ready), 64'd0);
      checkValue("stall_nzvc", 64'(nzvc), 64'b1000);
    end
    out_ready = 1'b1;
    step();
    checkValue("retire_no_accept", 64'(out_valid), 64'd0);

    applyStimulus(1, 0, 0, 64'h2, 4'b0101, 1, 64'h400, 26'd0, 1, 1);
    step();
    checkValue("squash_no_accept", 64'(out_valid), 64'd0);
    checkValue("squash_nzvc", 64'(nzvc), 64'b1000);

    applyStimulus(1, 0, 0, 64'h3, 4'b1111, 0, 64'h404, 26'd0, 0, 1);
    step();
    checkValue("noflags_nzvc", 64'(nzvc), 64'b1000);
    checkValue("noflags_valid", 64'(out_valid), 64'd1);

    applyStimulus(1, 2, 'hF, 64'h0, 4'b0000, 0, 64'hFFFF_FFFF_FFFF_FFFC, 26'd1, 0, 1);
    step();
    checkValue("wrap_taken", 64'(out_taken), 64'd1);
    checkValue("wrap_target", out_target, 64'h0);

    for (int i = 0; i < 400; i++) begin
      logic [63:0] r;
      r = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      applyStimulus($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 15), r,
                    4'($urandom), $urandom_range(0, 1), {$urandom, $urandom}, 26'($urandom),
                    $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
      step();
    end

    // Reset landing while an instruction is held at the output.
    applyStimulus(1, 1, 0, 64'h5, 4'b0110, 1, 64'h800, 26'd4, 0, 0);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    checkValue("midrst_out_valid", 64'(out_valid), 64'd0);
    checkValue("midrst_flush", 64'(flush), 64'd0);
    checkValue("midrst_nzvc", 64'(nzvc), 64'd0);
    m_valid = 1'b0;
    m_taken = 1'b0;
    m_nzvc  = 4'b0000;
    in_valid = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
